// File: rtl/vga_scan_controller.sv
`default_nettype none
// ============================================================================
// Module   : vga_scan_controller
// Purpose  : Raster scan sequencer for the debug display renderer. Divides the
//            system clock into a pixel tick, walks the full raster, registers
//            renderer colour with blanking and sync, and captures a per-frame
//            snapshot of the CPU debug values at vertical-blank start.
// Revision : 1.0 - initial release
// ============================================================================
module vga_scan_controller #(
  parameter int CLK_DIV = 2,
  parameter int H_VIS   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_VIS   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         freeze,
  input  logic [175:0] registerValueIn,
  input  logic [15:0]  IfPCIn,
  input  logic [15:0]  IfIRIn,
  input  logic [15:0]  calResultIn,
  input  logic [2:0]   rIn,
  input  logic [2:0]   gIn,
  input  logic [2:0]   bIn,
  output logic [10:0]  x,
  output logic [10:0]  y,
  output logic [175:0] registerValue,
  output logic [15:0]  IfPC,
  output logic [15:0]  IfIR,
  output logic [15:0]  calResult,
  output logic [2:0]   vgaR,
  output logic [2:0]   vgaG,
  output logic [2:0]   vgaB,
  output logic         hs,
  output logic         vs,
  output logic         frameTick
);

  localparam int c_h_total = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int c_v_total = V_VIS + V_FP + V_SYNC + V_BP;
  // A one-bit divider counter is kept even for CLK_DIV = 1; it then stays 0.
  localparam int c_div_w   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);
  localparam logic [c_div_w-1:0] c_div_one  = c_div_w'(1);
  localparam logic [10:0] c_h_last   = 11'(c_h_total - 1);
  localparam logic [10:0] c_v_last   = 11'(c_v_total - 1);
  localparam logic [10:0] c_h_vis    = 11'(H_VIS);
  localparam logic [10:0] c_v_vis    = 11'(V_VIS);
  localparam logic [10:0] c_v_snap   = 11'(V_VIS - 1);
  localparam logic [10:0] c_hs_first = 11'(H_VIS + H_FP);
  localparam logic [10:0] c_hs_last  = 11'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [10:0] c_vs_first = 11'(V_VIS + V_FP);
  localparam logic [10:0] c_vs_last  = 11'(V_VIS + V_FP + V_SYNC - 1);

  logic [c_div_w-1:0] r_div_cnt;
  logic [10:0]        r_h_cnt;
  logic [10:0]        r_v_cnt;
  logic [2:0]         r_vga_r;
  logic [2:0]         r_vga_g;
  logic [2:0]         r_vga_b;
  logic               r_hs;
  logic               r_vs;
  logic               r_frame_tick;
  logic [175:0]       r_reg_val;
  logic [15:0]        r_if_pc;
  logic [15:0]        r_if_ir;
  logic [15:0]        r_cal_res;

  logic w_pix_tick;
  logic w_h_wrap;
  logic w_v_wrap;
  logic w_active;
  logic w_hs_n;
  logic w_vs_n;
  logic w_snap_evt;

  assign w_pix_tick = (r_div_cnt == c_div_last);
  assign w_h_wrap   = (r_h_cnt == c_h_last);
  assign w_v_wrap   = (r_v_cnt == c_v_last);
  assign w_active   = (r_h_cnt < c_h_vis) && (r_v_cnt < c_v_vis);
  assign w_hs_n     = !((r_h_cnt >= c_hs_first) && (r_h_cnt <= c_hs_last));
  assign w_vs_n     = !((r_v_cnt >= c_vs_first) && (r_v_cnt <= c_vs_last));
  // Last pixel of the last visible line: raster is about to enter vblank.
  assign w_snap_evt = w_pix_tick && w_h_wrap && (r_v_cnt == c_v_snap);

  // Pixel-tick divider: counts 0..CLK_DIV-1 and restarts on the tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div_cnt <= '0;
    end else if (w_pix_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + c_div_one;
    end
  end

  // Raster position: horizontal counter per tick, vertical counter per line wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_pix_tick) begin
      if (w_h_wrap) begin
        r_h_cnt <= '0;
        r_v_cnt <= w_v_wrap ? 11'd0 : r_v_cnt + 11'd1;
      end else begin
        r_h_cnt <= r_h_cnt + 11'd1;
      end
    end
  end

  // Colour and sync sampled from the same counter state so they stay aligned.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vga_r <= '0;
      r_vga_g <= '0;
      r_vga_b <= '0;
      r_hs    <= 1'b1;
      r_vs    <= 1'b1;
    end else if (w_pix_tick) begin
      r_vga_r <= w_active ? rIn : 3'd0;
      r_vga_g <= w_active ? gIn : 3'd0;
      r_vga_b <= w_active ? bIn : 3'd0;
      r_hs    <= w_hs_n;
      r_vs    <= w_vs_n;
    end
  end

  // Debug snapshot: reloaded once per frame at vblank start unless frozen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_reg_val <= '0;
      r_if_pc   <= '0;
      r_if_ir   <= '0;
      r_cal_res <= '0;
    end else if (w_snap_evt && !freeze) begin
      r_reg_val <= registerValueIn;
      r_if_pc   <= IfPCIn;
      r_if_ir   <= IfIRIn;
      r_cal_res <= calResultIn;
    end
  end

  // Frame tick: one-clock pulse after the snapshot edge, independent of freeze.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= w_snap_evt;
    end
  end

  assign x             = r_h_cnt;
  assign y             = r_v_cnt;
  assign vgaR          = r_vga_r;
  assign vgaG          = r_vga_g;
  assign vgaB          = r_vga_b;
  assign hs            = r_hs;
  assign vs            = r_vs;
  assign frameTick     = r_frame_tick;
  assign registerValue = r_reg_val;
  assign IfPC          = r_if_pc;
  assign IfIR          = r_if_ir;
  assign calResult     = r_cal_res;

endmodule
`default_nettype wire
